// File: rtl/tdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tdc_pkg                                                         |
// | Purpose  : Shared definitions for the TDC result path: averager state      |
// |            encoding, default measurement width and a sizing helper.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tdc_pkg;

  // Measurement width shared with the TDC measurement controller.
  localparam int C_COUNT_TIME_BITS = 16;

  // Largest supported averaging exponent (256 samples per result).
  localparam int C_AVG_LOG2_MAX = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } avg_state_t;

  // Sample counter needs at least one bit even when no averaging is done.
  function automatic int cnt_width(input int avg_log2);
    return (avg_log2 < 1) ? 1 : avg_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tdc_serializer                                                  |
// | Purpose  : Strobe-driven MSB-first parallel-to-serial shifter for readout  |
// |            words.                                                          |
// | Ports    : clk       - clock, rising edge                                  |
// |            rst       - asynchronous reset, active low                      |
// |            load      - load request (caller qualifies when loading legal)  |
// |            load_data - word to shift out                                   |
// |            shift     - one bit per asserted cycle while busy               |
// |            sdo       - serial data, shift-register MSB                     |
// |            busy      - transfer in progress                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tdc_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             sdo,
  output logic             busy
);

  localparam int                 C_CNT_W = $clog2(WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(WIDTH);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

  logic [WIDTH-1:0]   r_shreg;
  logic [C_CNT_W-1:0] r_bits;
  logic               r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_bits  <= '0;
      r_busy  <= 1'b0;
    end else if (load && !r_busy) begin
      r_shreg <= load_data;
      r_bits  <= C_FULL;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      // Busy is held for one cycle after the last bit is shifted so the
      // final bit-count-zero state is visible before the word is released.
      if (r_bits == '0) begin
        r_busy <= 1'b0;
      end else if (shift) begin
        r_shreg <= r_shreg << 1;
        r_bits  <= r_bits - C_ONE;
      end
    end
  end

  assign sdo  = r_shreg[WIDTH-1];
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/tdc_result_averager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tdc_result_averager                                             |
// | Purpose  : Captures count_time at the end of each TDC measurement (falling |
// |            edge of running), averages 2^AVG_LOG2 captures and offers the   |
// |            truncated mean on a valid/ack interface plus a serial readout.  |
// | Ports    : clk, rst (async, active low)                                    |
// |            running, count_time      - from measurement controller          |
// |            avg_ack                  - consumer acknowledge                 |
// |            ovr_clr                  - clears sticky overrun                |
// |            ser_load, ser_shift      - serial readout control               |
// |            avg_valid, avg_out       - averaged result                      |
// |            overrun                  - a capture was dropped while holding  |
// |            sdo, ser_busy            - serial readout                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tdc_result_averager
  import tdc_pkg::*;
#(
  parameter int COUNT_TIME_BITS = C_COUNT_TIME_BITS,
  parameter int AVG_LOG2        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       running,
  input  logic [COUNT_TIME_BITS-1:0] count_time,
  input  logic                       avg_ack,
  input  logic                       ovr_clr,
  input  logic                       ser_load,
  input  logic                       ser_shift,
  output logic                       avg_valid,
  output logic [COUNT_TIME_BITS-1:0] avg_out,
  output logic                       overrun,
  output logic                       sdo,
  output logic                       ser_busy
);

  // Accumulator carries AVG_LOG2 guard bits so a full set of max-value
  // samples cannot overflow.
  localparam int                 C_ACC_W = COUNT_TIME_BITS + AVG_LOG2;
  localparam int                 C_CNT_W = cnt_width(AVG_LOG2);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'((2 ** AVG_LOG2) - 1);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

  avg_state_t                 r_state;
  logic                       r_running_d;
  logic [C_ACC_W-1:0]         r_acc;
  logic [C_CNT_W-1:0]         r_cnt;
  logic                       r_avg_valid;
  logic [COUNT_TIME_BITS-1:0] r_avg_out;
  logic                       r_overrun;

  logic                       w_capture;
  logic [C_ACC_W-1:0]         w_sum;
  logic [COUNT_TIME_BITS-1:0] w_mean;
  logic                       w_ser_load;
  logic                       w_ser_busy;

  assign w_capture = r_running_d & ~running;
  assign w_sum     = r_acc + C_ACC_W'(count_time);
  // Dropping the low AVG_LOG2 bits is the truncating divide.
  assign w_mean    = w_sum[AVG_LOG2 +: COUNT_TIME_BITS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ACCUM;
      r_running_d <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg_valid <= 1'b0;
      r_avg_out   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_running_d <= running;

      case (r_state)
        ACCUM: begin
          if (w_capture) begin
            if (r_cnt != C_LAST) begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + C_ONE;
            end else begin
              r_avg_out   <= w_mean;
              r_avg_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // The result must not be released while it is still being
          // shifted out; the consumer re-asserts ack afterwards.
          if (avg_ack && !w_ser_busy) begin
            r_avg_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase

      // A drop in the same cycle as a clear must remain visible.
      if ((r_state == HOLD) && w_capture) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign w_ser_load = ser_load && (r_state == HOLD);

  tdc_serializer #(
    .WIDTH (COUNT_TIME_BITS)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (w_ser_load),
    .load_data (r_avg_out),
    .shift     (ser_shift),
    .sdo       (sdo),
    .busy      (w_ser_busy)
  );

  assign avg_valid = r_avg_valid;
  assign avg_out   = r_avg_out;
  assign overrun   = r_overrun;
  assign ser_busy  = w_ser_busy;

endmodule
`default_nettype wire

// File: tb/tb_tdc_result_averager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tdc_result_averager                                          |
// | Purpose  : Self-checking bench for tdc_result_averager. Two instances:     |
// |            index 0 averages 4 samples, index 1 passes samples through.     |
// |            Expected values come from a sample-sum reference model.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tdc_result_averager;

  logic        clk;
  logic        rst;
  logic [1:0]  running;
  logic [15:0] ct [2];
  logic [1:0]  avg_ack;
  logic [1:0]  ovr_clr;
  logic [1:0]  ser_load;
  logic [1:0]  ser_shift;
  logic [1:0]  avg_valid;
  logic [15:0] avg_out [2];
  logic [1:0]  overrun;
  logic [1:0]  sdo;
  logic [1:0]  ser_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, per instance.
  int          m_log2 [2] = '{2, 0};
  longint      m_sum  [2];
  int          m_n    [2];
  bit          m_hold [2];
  bit          m_valid[2];
  bit          m_ovr  [2];
  bit          m_busy [2];
  logic [15:0] m_out  [2];

  tdc_result_averager #(.COUNT_TIME_BITS(16), .AVG_LOG2(2)) dut_a (
    .clk(clk), .rst(rst), .running(running[0]), .count_time(ct[0]),
    .avg_ack(avg_ack[0]), .ovr_clr(ovr_clr[0]), .ser_load(ser_load[0]),
    .ser_shift(ser_shift[0]), .avg_valid(avg_valid[0]), .avg_out(avg_out[0]),
    .overrun(overrun[0]), .sdo(sdo[0]), .ser_busy(ser_busy[0])
  );

  tdc_result_averager #(.COUNT_TIME_BITS(16), .AVG_LOG2(0)) dut_b (
    .clk(clk), .rst(rst), .running(running[1]), .count_time(ct[1]),
    .avg_ack(avg_ack[1]), .ovr_clr(ovr_clr[1]), .ser_load(ser_load[1]),
    .ser_shift(ser_shift[1]), .avg_valid(avg_valid[1]), .avg_out(avg_out[1]),
    .overrun(overrun[1]), .sdo(sdo[1]), .ser_busy(ser_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sum[d] = 0; m_n[d] = 0; m_hold[d] = 0; m_valid[d] = 0;
      m_ovr[d] = 0; m_busy[d] = 0; m_out[d] = '0;
    end
  endtask

  task automatic check(input int d, input string tag);
    cmp({tag, "_valid"},   32'(avg_valid[d]), 32'(m_valid[d]));
    cmp({tag, "_out"},     32'(avg_out[d]),   32'(m_out[d]));
    cmp({tag, "_overrun"}, 32'(overrun[d]),   32'(m_ovr[d]));
    cmp({tag, "_busy"},    32'(ser_busy[d]),  32'(m_busy[d]));
  endtask

  // One measurement: running high for hi cycles, then falling with the
  // value already on count_time. Returns one cycle after the capture event.
  task automatic capture(input int d, input logic [15:0] v, input bit with_clr, input int hi);
    longint div;
    running[d] = 1'b1;
    ct[d]      = v;
    repeat (hi) tick();
    running[d] = 1'b0;
    if (with_clr) ovr_clr[d] = 1'b1;
    cmp("pre_capture_valid", 32'(avg_valid[d]), 32'(m_valid[d]));
    tick();
    ovr_clr[d] = 1'b0;
    div = longint'(1) << m_log2[d];
    if (m_hold[d]) begin
      m_ovr[d] = 1;
    end else begin
      if (with_clr) m_ovr[d] = 0;
      m_sum[d] += longint'(v);
      m_n[d]++;
      if (m_n[d] == div) begin
        m_out[d]   = 16'(m_sum[d] / div);
        m_valid[d] = 1;
        m_hold[d]  = 1;
        m_sum[d]   = 0;
        m_n[d]     = 0;
      end
    end
  endtask

  task automatic ack(input int d);
    avg_ack[d] = 1'b1;
    tick();
    avg_ack[d] = 1'b0;
    if (m_hold[d] && !m_busy[d]) begin
      m_valid[d] = 0;
      m_hold[d]  = 0;
    end
  endtask

  task automatic clear_ovr(input int d);
    ovr_clr[d] = 1'b1;
    tick();
    ovr_clr[d] = 1'b0;
    m_ovr[d] = 0;
  endtask

  initial begin
    logic [15:0] word;
    rst       = 1'b0;
    running   = '0;
    ct[0]     = '0;
    ct[1]     = '0;
    avg_ack   = '0;
    ovr_clr   = '0;
    ser_load  = '0;
    ser_shift = '0;
    model_reset();

    repeat (3) tick();
    check(0, "reset_a");
    check(1, "reset_b");
    cmp("reset_sdo_a", 32'(sdo[0]), 32'd0);
    rst = 1'b1;
    tick();

    // Basic average: (100+101+102+104)/4 = 101.
    capture(0, 16'd100, 1'b0, 1);
    capture(0, 16'd101, 1'b0, 1);
    capture(0, 16'd102, 1'b0, 1);
    check(0, "avg1_partial");
    capture(0, 16'd104, 1'b0, 1);
    check(0, "avg1");
    cmp("avg1_out_const", 32'(avg_out[0]), 32'd101);
    check(1, "avg1_b_idle");

    // Fifth capture while holding is dropped.
    capture(0, 16'd55, 1'b0, 2);
    check(0, "overrun_set");
    ack(0);
    check(0, "after_ack");
    capture(0, 16'($urandom_range(0, 65535)), 1'b0, 6);
    for (int i = 0; i < 3; i++) capture(0, 16'($urandom_range(0, 65535)), 1'b0, 1 + i);
    check(0, "fresh_avg");
    clear_ovr(0);
    check(0, "ovr_cleared");

    // Drop and clear in the same cycle: the drop wins.
    capture(0, 16'd3, 1'b1, 1);
    check(0, "drop_wins");
    clear_ovr(0);
    check(0, "ovr_cleared2");
    ack(0);

    // Maximum samples must not overflow the accumulator.
    for (int i = 0; i < 4; i++) capture(0, 16'hFFFF, 1'b0, 1);
    check(0, "max_avg");
    ack(0);

    // Serial load in ACCUM is ignored.
    ser_load[0] = 1'b1;
    tick();
    ser_load[0] = 1'b0;
    tick();
    check(0, "load_in_accum");

    // Serial readout of 16'hA5C3.
    word = 16'hA5C3;
    for (int i = 0; i < 4; i++) capture(0, word, 1'b0, 1);
    check(0, "ser_word");
    ser_load[0] = 1'b1;
    tick();
    ser_load[0] = 1'b0;
    m_busy[0] = 1;
    check(0, "ser_loaded");
    for (int i = 0; i < 16; i++) begin
      cmp("ser_sdo_bit", 32'(sdo[0]), 32'(word[15 - i]));
      ser_shift[0] = 1'b1;
      tick();
      ser_shift[0] = 1'b0;
      if (i == 5) begin
        ack(0);
        check(0, "ack_during_shift");
      end
      repeat ($urandom_range(0, 2)) tick();
      if (i < 15) cmp("ser_busy_mid", 32'(ser_busy[0]), 32'd1);
    end
    tick();
    tick();
    m_busy[0] = 0;
    check(0, "ser_done");
    cmp("ser_sdo_drained", 32'(sdo[0]), 32'd0);
    ack(0);
    check(0, "ack_after_shift");

    // Pass-through instance.
    capture(1, 16'd7, 1'b0, 1);
    check(1, "pass_7");
    ack(1);
    check(1, "pass_ack");
    capture(1, 16'd9, 1'b0, 1);
    check(1, "pass_9");
    ack(1);

    // Randomised averages on both instances.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++)
        capture(0, 16'($urandom_range(0, 65535)), 1'b0, int'($urandom_range(1, 4)));
      check(0, "rand_avg_a");
      if ($urandom_range(0, 1) == 1) begin
        capture(0, 16'($urandom_range(0, 65535)), 1'b0, 1);
        check(0, "rand_drop_a");
        clear_ovr(0);
      end
      ack(0);
      capture(1, 16'($urandom_range(0, 65535)), 1'b0, int'($urandom_range(1, 3)));
      check(1, "rand_pass_b");
      ack(1);
    end

    // Asynchronous reset mid-accumulation.
    capture(0, 16'd1000, 1'b0, 1);
    capture(0, 16'd2000, 1'b0, 1);
    capture(1, 16'd1234, 1'b0, 1);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check(0, "async_rst_a");
    check(1, "async_rst_b");
    cmp("async_rst_sdo", 32'(sdo[0]), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) capture(0, 16'd8, 1'b0, 1);
    check(0, "post_rst_avg");
    cmp("post_rst_out_const", 32'(avg_out[0]), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
